branch_predictor: RTL and testbench

//  Next-generation branch unit: 2-bit saturating-counter predictor plus registered branch resolver.

---
 rtl/branch_predictor_pkg.sv | 58 +++++
 rtl/branch_predictor_cond_eval.sv | 35 +++
 rtl/branch_predictor.sv | 138 +++++++++++++
 tb/tb_branch_predictor.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch unit: opcode masks, condition codes,
// 2-bit counter encodings and the decode/saturating-step helpers.
package branch_predictor_pkg;

    localparam int OPCODESIZE  = 11;
    localparam int REGADDRSIZE = 5;
    localparam int FLAGSIZE    = 4;

    // Each branch class is matched as (opcode & MASK) == VALUE.
    localparam logic [OPCODESIZE-1:0] OP_B_MASK     = 11'b111111_00000;
    localparam logic [OPCODESIZE-1:0] OP_B          = 11'b000101_00000;
    localparam logic [OPCODESIZE-1:0] OP_CB_MASK    = 11'b1111111_0000;
    localparam logic [OPCODESIZE-1:0] OP_CB         = 11'b1011010_0000;
    localparam logic [OPCODESIZE-1:0] OP_BFLAG_MASK = 11'b11111111_000;
    localparam logic [OPCODESIZE-1:0] OP_BFLAG      = 11'b01010100_000;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD
    } cond_e;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    typedef enum logic [1:0] {
        BR_NONE,
        BR_B,
        BR_CB,
        BR_BCOND
    } br_kind_e;

    function automatic br_kind_e decode_branch(input logic [OPCODESIZE-1:0] op);
        if ((op & OP_B_MASK) == OP_B)
            return BR_B;
        else if ((op & OP_CB_MASK) == OP_CB)
            return BR_CB;
        else if ((op & OP_BFLAG_MASK) == OP_BFLAG)
            return BR_BCOND;
        else
            return BR_NONE;
    endfunction

    function automatic cnt_e cnt_step(input cnt_e c, input logic taken);
        case (c)
            CNT_SNT: return taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: return taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  return taken ? CNT_ST  : CNT_WNT;
            default: return taken ? CNT_ST  : CNT_WT;
        endcase
    endfunction

endpackage

// File: rtl/branch_predictor_cond_eval.sv
// Combinational condition-code evaluator: {N,Z,V,C} flags plus a 4-bit
// condition -> taken. Codes E and F are never taken.
module cond_eval
    import branch_predictor_pkg::*;
(
    input  logic [FLAGSIZE-1:0] flags_i,
    input  logic [3:0]          cond_i,
    output logic                taken_o
);

    logic n, z, v, c;
    assign {n, z, v, c} = flags_i;

    always_comb begin
        taken_o = 1'b0;
        case (cond_e'(cond_i))
            COND_EQ: taken_o = z;
            COND_NE: taken_o = ~z;
            COND_HS: taken_o = c;
            COND_LO: taken_o = ~c;
            COND_MI: taken_o = n;
            COND_PL: taken_o = ~n;
            COND_VS: taken_o = v;
            COND_VC: taken_o = ~v;
            COND_HI: taken_o = c & ~z;
            COND_LS: taken_o = ~(c & ~z);
            COND_GE: taken_o = (n == v);
            COND_LT: taken_o = (n != v);
            COND_GT: taken_o = ~z & (n == v);
            COND_LE: taken_o = ~(~z & (n == v));
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter branch predictor with a registered resolver.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter int IDXBITS  = 4,
    parameter int STATBITS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pvalid,
    input  logic [WORDSIZE-1:0]    ppc,
    output logic                   ptakenvalid,
    output logic                   ptaken,
    input  logic                   rvalid,
    input  logic [WORDSIZE-1:0]    rpc,
    input  logic [OPCODESIZE-1:0]  ropcode,
    input  logic [WORDSIZE-1:0]    rreadreg2,
    input  logic [REGADDRSIZE-1:0] rrd,
    input  logic [FLAGSIZE-1:0]    rflags,
    input  logic                   rpredtaken,
    output logic                   resvalid,
    output logic                   restaken,
`ifdef BRANCH_STATS_EN
    output logic                   mispredict,
    output logic [STATBITS-1:0]    nbranches,
    output logic [STATBITS-1:0]    nmispredict
`else
    output logic                   mispredict
`endif
);

    localparam int DEPTH = 1 << IDXBITS;

    cnt_e [DEPTH-1:0]   table_q;
    cnt_e [DEPTH-1:0]   table_d;
    logic [IDXBITS-1:0] pidx;
    logic [IDXBITS-1:0] ridx;
    logic [1:0]         pent;
    br_kind_e           kind;
    logic               cond_taken;
    logic               taken;
    logic               upd_en;
    logic               mispredict_d;

    logic ptakenvalid_q, ptaken_q;
    logic resvalid_q, restaken_q, mispredict_q;

    // PCs are word aligned, so the low two bits never select an entry.
    assign pidx = ppc[IDXBITS+1:2];
    assign ridx = rpc[IDXBITS+1:2];
    assign pent = table_q[pidx];

    logic unused_bits;
    assign unused_bits = ^{ppc[WORDSIZE-1:IDXBITS+2], ppc[1:0],
                           rpc[WORDSIZE-1:IDXBITS+2], rpc[1:0],
                           rrd[REGADDRSIZE-1:4]};

    assign kind = decode_branch(ropcode);

    cond_eval u_cond_eval (
        .flags_i (rflags),
        .cond_i  (rrd[3:0]),
        .taken_o (cond_taken)
    );

    always_comb begin
        taken = 1'b0;
        case (kind)
            BR_B:     taken = 1'b1;
            BR_CB:    taken = (rreadreg2 == '0) ^ ropcode[3];
            BR_BCOND: taken = cond_taken;
            default:  taken = 1'b0;
        endcase
    end

    assign upd_en       = rvalid && (kind != BR_NONE);
    assign mispredict_d = rvalid && (taken != rpredtaken);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign table_d[gi] = (upd_en && (ridx == IDXBITS'(gi)))
                               ? cnt_step(table_q[gi], taken)
                               : table_q[gi];
        end
    endgenerate

    // Prediction reads table_q, so a same-cycle update is seen only next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                table_q[i] <= CNT_WNT;
            ptakenvalid_q <= 1'b0;
            ptaken_q      <= 1'b0;
            resvalid_q    <= 1'b0;
            restaken_q    <= 1'b0;
            mispredict_q  <= 1'b0;
        end else begin
            table_q       <= table_d;
            ptakenvalid_q <= pvalid;
            ptaken_q      <= pvalid & pent[1];
            resvalid_q    <= rvalid;
            restaken_q    <= rvalid & taken;
            mispredict_q  <= mispredict_d;
        end
    end

    assign ptakenvalid = ptakenvalid_q;
    assign ptaken      = ptaken_q;
    assign resvalid    = resvalid_q;
    assign restaken    = restaken_q;
    assign mispredict  = mispredict_q;

`ifdef BRANCH_STATS_EN
    logic [STATBITS-1:0] nbranches_q;
    logic [STATBITS-1:0] nmispredict_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            nbranches_q   <= '0;
            nmispredict_q <= '0;
        end else begin
            if (upd_en && !(&nbranches_q))
                nbranches_q <= nbranches_q + STATBITS'(1);
            if (mispredict_d && !(&nmispredict_q))
                nmispredict_q <= nmispredict_q + STATBITS'(1);
        end
    end

    assign nbranches   = nbranches_q;
    assign nmispredict = nmispredict_q;
`else
    localparam int UNUSED_STATBITS = STATBITS;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed vectors push expectations,
// a negedge monitor pops and compares every ptakenvalid / resvalid response.
module tb_branch_predictor;

    localparam logic [10:0] OPC_B     = 11'b00010100000;
    localparam logic [10:0] OPC_CBZ   = 11'b10110100000;
    localparam logic [10:0] OPC_CBNZ  = 11'b10110101000;
    localparam logic [10:0] OPC_BCOND = 11'b01010100000;
    localparam logic [10:0] OPC_ADD   = 11'b10001011000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pvalid = 1'b0;
    logic [63:0] ppc = '0;
    logic        ptakenvalid, ptaken;
    logic        rvalid = 1'b0;
    logic [63:0] rpc = '0;
    logic [10:0] ropcode = '0;
    logic [63:0] rreadreg2 = '0;
    logic [4:0]  rrd = '0;
    logic [3:0]  rflags = '0;
    logic        rpredtaken = 1'b0;
    logic        resvalid, restaken, mispredict;
`ifdef BRANCH_STATS_EN
    logic [15:0] nbranches, nmispredict;
`endif

    always #5 clk = ~clk;

    branch_predictor #(.WORDSIZE(64), .IDXBITS(4), .STATBITS(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .pvalid      (pvalid),
        .ppc         (ppc),
        .ptakenvalid (ptakenvalid),
        .ptaken      (ptaken),
        .rvalid      (rvalid),
        .rpc         (rpc),
        .ropcode     (ropcode),
        .rreadreg2   (rreadreg2),
        .rrd         (rrd),
        .rflags      (rflags),
        .rpredtaken  (rpredtaken),
        .resvalid    (resvalid),
        .restaken    (restaken),
`ifdef BRANCH_STATS_EN
        .mispredict  (mispredict),
        .nbranches   (nbranches),
        .nmispredict (nmispredict)
`else
        .mispredict  (mispredict)
`endif
    );

    typedef struct {
        string tag;
        logic  a;
        logic  b;
    } exp_t;

    exp_t pq[$];
    exp_t rq[$];
    int   nvec = 0;
    int   nfail = 0;
    bit   quiet = 1'b0;
    int   stat_br = 0;
    int   stat_mis = 0;

    function automatic void chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end else if (!quiet) begin
            $display("ok   %s got %0h", tag, got);
        end
    endfunction

    // Reference for B.cond: base test on code[3:1], inverted by code[0].
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cf, base;
        {n, z, v, cf} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b0;
        endcase
        return (c[3:1] == 3'd7) ? 1'b0 : (base ^ c[0]);
    endfunction

    always @(negedge clk) begin
        if (ptakenvalid) begin
            if (pq.size() == 0) begin
                chk("unexpected_pred", 64'(ptakenvalid), 64'd0);
            end else begin
                exp_t e;
                e = pq.pop_front();
                chk({"pred_", e.tag}, 64'(ptaken), 64'(e.a));
            end
        end
        if (resvalid) begin
            if (rq.size() == 0) begin
                chk("unexpected_res", 64'(resvalid), 64'd0);
            end else begin
                exp_t e;
                e = rq.pop_front();
                chk({"res_", e.tag}, 64'({restaken, mispredict}), 64'({e.a, e.b}));
            end
        end
    end

    task automatic pred(input logic [63:0] pc, input logic exp_taken, input string tag);
        pvalid = 1'b1;
        ppc    = pc;
        if (!reset) pq.push_back('{tag, exp_taken, 1'b0});
    endtask

    task automatic res(input logic [63:0] pc, input logic [10:0] op, input logic [63:0] reg2,
                       input logic [4:0] rd, input logic [3:0] flags, input logic predt,
                       input logic exp_taken, input bit is_br, input string tag);
        rvalid     = 1'b1;
        rpc        = pc;
        ropcode    = op;
        rreadreg2  = reg2;
        rrd        = rd;
        rflags     = flags;
        rpredtaken = predt;
        if (!reset) begin
            rq.push_back('{tag, exp_taken, exp_taken != predt});
            if (is_br) stat_br++;
            if (exp_taken != predt) stat_mis++;
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        pvalid = 1'b0;
        rvalid = 1'b0;
    endtask

    task automatic drain;
        int k;
        k = 0;
        while ((pq.size() != 0 || rq.size() != 0) && k < 10) begin
            @(negedge clk);
            k++;
        end
        #1;
        chk("drain_pending", 64'(pq.size() + rq.size()), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_ptakenvalid"}, 64'(ptakenvalid), 64'd0);
        chk({tag, "_ptaken"},      64'(ptaken),      64'd0);
        chk({tag, "_resvalid"},    64'(resvalid),    64'd0);
        chk({tag, "_restaken"},    64'(restaken),    64'd0);
        chk({tag, "_mispredict"},  64'(mispredict),  64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        step;
        step;
        check_idle("reset");
`ifdef BRANCH_STATS_EN
        chk("reset_nbranches",   64'(nbranches),   64'd0);
        chk("reset_nmispredict", 64'(nmispredict), 64'd0);
`endif
        reset = 1'b0;

        // Initial weak-not-taken, then train idx 0 with two B resolves.
        pred(64'h40, 1'b0, "init_0x40");                             step;
        res(64'h40, OPC_B, 64'd0, 5'd0, 4'd0, 1'b0, 1'b1, 1, "b1");   step;
        res(64'h40, OPC_B, 64'd0, 5'd0, 4'd0, 1'b1, 1'b1, 1, "b2");   step;
        pred(64'h40, 1'b1, "trained_0x40");                          step;

        res(64'h44, OPC_CBZ,  64'd0, 5'd0, 4'd0, 1'b0, 1'b1, 1, "cbz_zero");    step;
        res(64'h48, OPC_CBNZ, 64'd5, 5'd0, 4'd0, 1'b1, 1'b1, 1, "cbnz_five");   step;
        res(64'h44, OPC_CBZ,  64'd5, 5'd0, 4'd0, 1'b0, 1'b0, 1, "cbz_five");    step;
        res(64'h48, OPC_CBNZ, 64'd0, 5'd0, 4'd0, 1'b1, 1'b0, 1, "cbnz_zero");   step;

        // Directed condition points, then a full sweep against the model.
        res(64'h80, OPC_BCOND, 64'd0, 5'd12, 4'b1010, 1'b0, 1'b1, 1, "gt_nv_set"); step;
        res(64'h80, OPC_BCOND, 64'd0, 5'd14, 4'b0100, 1'b1, 1'b0, 1, "code_e");    step;
        res(64'h80, OPC_BCOND, 64'd0, 5'd15, 4'b1111, 1'b0, 1'b0, 1, "code_f");    step;
        quiet = 1'b1;
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                logic [3:0] cc, ff;
                cc = 4'(c);
                ff = 4'(f);
                res(64'h80, OPC_BCOND, 64'd0, {1'b0, cc}, ff, cc[0] ^ ff[0],
                    cond_model(cc, ff), 1, $sformatf("bcond_c%0d_f%0d", c, f));
                step;
            end
        end
        drain();
        quiet = 1'b0;

        // Saturate idx 15 at 00, then show read-before-write on two updates.
        for (int i = 0; i < 5; i++) begin
            res(64'h3C, OPC_CBZ, 64'd5, 5'd0, 4'd0, 1'b0, 1'b0, 1, $sformatf("sat_nt%0d", i));
            step;
        end
        pred(64'h3C, 1'b0, "sat_00");                                    step;
        pred(64'h3C, 1'b0, "rbw_00");
        res(64'h3C, OPC_B, 64'd0, 5'd0, 4'd0, 1'b0, 1'b1, 1, "rbw_up1"); step;
        pred(64'h3C, 1'b0, "after_01");                                  step;
        pred(64'h3C, 1'b0, "rbw_01");
        res(64'h3C, OPC_B, 64'd0, 5'd0, 4'd0, 1'b0, 1'b1, 1, "rbw_up2"); step;
        pred(64'h3C, 1'b1, "after_10");                                  step;

        // Non-branch false hits flush but leave the table alone.
        for (int i = 0; i < 3; i++) begin
            res(64'h3C, OPC_ADD, 64'd0, 5'd0, 4'd0, 1'b1, 1'b0, 0, $sformatf("add_false_hit%0d", i));
            step;
        end
        pred(64'h3C, 1'b1, "after_add");                                 step;
        drain();

        // Reset mid-stream: in-flight requests are dropped.
        reset = 1'b1;
        pred(64'h3C, 1'b0, "in_reset");
        res(64'h3C, OPC_B, 64'd0, 5'd0, 4'd0, 1'b0, 1'b1, 1, "in_reset");
        step;
        check_idle("midreset");
`ifdef BRANCH_STATS_EN
        chk("midreset_nbranches", 64'(nbranches), 64'd0);
`endif
        reset = 1'b0;
        stat_br = 0;
        stat_mis = 0;

        // Every entry must be 01: one taken resolve flips prediction to taken.
        for (int i = 0; i < 16; i++) begin
            res(64'(i * 4), OPC_B, 64'd0, 5'd0, 4'd0, 1'b0, 1'b1, 1, $sformatf("post_b_idx%0d", i));
            step;
            pred(64'(i * 4), 1'b1, $sformatf("post_idx%0d", i));
            step;
        end
        drain();

`ifdef BRANCH_STATS_EN
        chk("stat_nbranches",   64'(nbranches),   64'(stat_br));
        chk("stat_nmispredict", 64'(nmispredict), 64'(stat_mis));
        quiet = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            res(64'h0, OPC_B, 64'd0, 5'd0, 4'd0, 1'b0, 1'b1, 1, "stat_fill");
            step;
        end
        drain();
        quiet = 1'b0;
        chk("stat_nbranches_sat",   64'(nbranches),   64'hFFFF);
        chk("stat_nmispredict_sat", 64'(nmispredict), 64'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
